// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 UART receiver assembling 64-byte frames into midstate/data2 work words
module serial_receiver #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         RxD,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic         frame_done
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(TO + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [5:0] byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic [511:0] frame_buf, frame_nx;
  logic tick, start_det, accept, ferr, timeout, last;
  always_comb begin
    tick = cnt == CW'(state == START ? HALF - 1 : CLKS_PER_BIT - 1);
    start_det = state == IDLE && !rx_s;
    accept = state == STOP && tick && rx_s;
    ferr = state == STOP && tick && !rx_s;
    timeout = state == IDLE && byte_cnt != 6'd0 && idle_cnt == IW'(TO - 1);
    last = accept && byte_cnt == 6'd63;
    frame_nx = {frame_buf[503:0], shreg};
    state_nx = state;
    case (state)
      IDLE:    state_nx = rx_s ? IDLE : START;
      START:   state_nx = !tick ? START : rx_s ? IDLE : DATA;
      DATA:    state_nx = tick && bit_idx == 3'd7 ? STOP : DATA;
      default: state_nx = tick ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {rx_m, rx_s} <= 2'b11;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      frame_buf <= '0;
      midstate <= '0;
      data2 <= '0;
      frame_done <= 1'b0;
    end else begin
      {rx_m, rx_s} <= {RxD, rx_m};
      cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
      bit_idx <= start_det ? '0 : bit_idx + 3'(state == DATA && tick);
      if (state == DATA && tick) shreg <= {rx_s, shreg[7:1]};
      byte_cnt <= ferr || timeout ? '0 : byte_cnt + 6'(accept);
      // idle timer only guards a partially received frame
      idle_cnt <= state == IDLE && byte_cnt != 6'd0 && !start_det && !timeout ? idle_cnt + 1'b1 : '0;
      if (accept) frame_buf <= frame_nx;
      frame_done <= last;
      if (last) {midstate, data2} <= frame_nx;
    end
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: random 8N1 frames checked against a byte-queue reference model
module tb_serial_receiver;
  localparam int CPB = 8;
  localparam int TOB = 32;
  logic clk = 1'b0, reset_n = 1'b0, RxD = 1'b1;
  logic [255:0] midstate, data2;
  logic frame_done;
  int vectors = 0, miscompares = 0;
  int pulses = 0, exp_pulses = 0, wide = 0, stray = 0;
  logic [7:0] q[$];
  logic [7:0] f[64];
  logic [255:0] exp_mid = '0, exp_d2 = '0, exp_pre_mid = '0, exp_pre_d2 = '0;
  logic [255:0] prev_mid = '0, prev_d2 = '0, pre_mid = '0, pre_d2 = '0;
  logic prev_fd = 1'b0;

  always #5 clk = ~clk;

  serial_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset_n(reset_n), .RxD(RxD),
    .midstate(midstate), .data2(data2), .frame_done(frame_done)
  );

  always @(negedge clk) begin
    if (frame_done) begin
      pulses++;
      pre_mid = prev_mid;
      pre_d2 = prev_d2;
      if (prev_fd) wide++;
    end else if (reset_n && (midstate !== prev_mid || data2 !== prev_d2)) stray++;
    prev_mid = midstate;
    prev_d2 = data2;
    prev_fd = frame_done;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      q.delete();
      return;
    end
    q.push_back(b);
    if (q.size() == 64) begin
      exp_pre_mid = exp_mid;
      exp_pre_d2 = exp_d2;
      for (int i = 0; i < 32; i++) begin
        exp_mid[255-8*i -: 8] = q[i];
        exp_d2[255-8*i -: 8] = q[32+i];
      end
      exp_pulses++;
      q.delete();
    end
  endfunction

  function automatic void model_idle(input int bits);
    if (bits > TOB) q.delete();
  endfunction

  function automatic void model_reset();
    q.delete();
    exp_mid = '0;
    exp_d2 = '0;
    exp_pre_mid = '0;
    exp_pre_d2 = '0;
  endfunction

  task automatic bit_time(input logic v, input int n);
    RxD = v;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(b[i], 1);
    bit_time(ok, 1);
    model_byte(b, ok);
    if (!ok) bit_time(1'b1, 2);
  endtask

  task automatic send_frame(input int maxgap);
    int gap;
    for (int i = 0; i < 64; i++) begin
      send_byte(f[i], 1'b1);
      gap = $urandom_range(maxgap, 0);
      if (gap > 0) bit_time(1'b1, gap);
    end
  endtask

  task automatic check_state(input string tag);
    bit_time(1'b1, 1);
    chk({tag, "_pulses"}, 256'(pulses), 256'(exp_pulses));
    chk({tag, "_mid"}, midstate, exp_mid);
    chk({tag, "_d2"}, data2, exp_d2);
    chk({tag, "_pre_mid"}, pre_mid, exp_pre_mid);
    chk({tag, "_pre_d2"}, pre_d2, exp_pre_d2);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid", midstate, '0);
    chk("rst_d2", data2, '0);
    chk("rst_fd", 256'(frame_done), '0);
    reset_n = 1'b1;
    bit_time(1'b1, 2);
    for (int i = 0; i < 64; i++) f[i] = 8'(i);
    send_frame(0);
    check_state("seq");
    for (int i = 0; i < 63; i++) send_byte(8'h55, 1'b1);
    bit_time(1'b1, 40);
    model_idle(40);
    for (int i = 0; i < 64; i++) f[i] = 8'hAA;
    send_frame(0);
    check_state("timeout");
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), i != 10);
    bit_time(1'b1, 40);
    model_idle(40);
    for (int i = 0; i < 64; i++) f[i] = 8'h11;
    send_frame(1);
    check_state("ferr");
    repeat (5) begin
      RxD = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      #1;
      bit_time(1'b1, 2);
    end
    for (int i = 0; i < 64; i++) f[i] = 8'($urandom);
    send_frame(2);
    check_state("glitch");
    for (int i = 0; i < 29; i++) send_byte(8'($urandom), 1'b1);
    bit_time(1'b0, 1);
    bit_time(1'b1, 1);
    bit_time(1'b0, 1);
    #3 reset_n = 1'b0;
    model_reset();
    RxD = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst2_mid", midstate, '0);
    chk("rst2_d2", data2, '0);
    chk("rst2_fd", 256'(frame_done), '0);
    reset_n = 1'b1;
    bit_time(1'b1, 2);
    chk("rst2_hold_mid", midstate, '0);
    for (int i = 0; i < 64; i++) f[i] = 8'($urandom);
    send_frame(1);
    check_state("reset");
    for (int i = 0; i < 64; i++) f[i] = 8'h01;
    send_frame(0);
    for (int i = 0; i < 64; i++) f[i] = 8'hFE;
    send_frame(0);
    check_state("pair");
    repeat (2) begin
      for (int i = 0; i < 64; i++) f[i] = 8'($urandom);
      send_frame(3);
      check_state("rand");
    end
    chk("fd_width", 256'(wide), '0);
    chk("stray_change", 256'(stray), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
